// File: rtl/pico_receiver.sv
// PICO-side deserializer: turns an LSB-first serial command/data stream into
// register-file writes and read requests for the POCI transmitter.
module pico_receiver #(
  parameter int NUM_REGS = 59
) (
  input  logic                     sclk,
  input  logic                     rstn,
  input  logic                     cs_n,
  input  logic                     pico,
  output logic [NUM_REGS-1:0][7:0] regs,
  output logic [7:0]               read_addr,
  output logic                     read_load,
  output logic                     write_strobe,
  output logic [7:0]               write_addr,
  output logic                     addr_err
);

  localparam logic [7:0] MAX_ADDR = 8'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_RHOLD,
    S_DISCARD
  } state_e;

  state_e                    state_q, state_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [7:0]                shift_q, shift_d;
  logic [7:0]                ptr_q, ptr_d;
  logic                      ovf_q, ovf_d;
  logic [NUM_REGS-1:0][7:0]  regs_q, regs_d;
  logic [7:0]                read_addr_q, read_addr_d;
  logic [7:0]                write_addr_q, write_addr_d;
  logic                      read_load_q, read_load_d;
  logic                      write_strobe_q, write_strobe_d;
  logic                      addr_err_q, addr_err_d;

  logic [7:0] byte_in;
  logic [7:0] cmd_addr;
  logic [7:0] ptr_inc;
  logic       byte_done;

  assign byte_in   = {pico, shift_q[7:1]};
  assign cmd_addr  = {1'b0, byte_in[6:0]};
  assign ptr_inc   = ptr_q + 8'd1;
  assign byte_done = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    ptr_d          = ptr_q;
    ovf_d          = ovf_q;
    regs_d         = regs_q;
    read_addr_d    = read_addr_q;
    write_addr_d   = write_addr_q;
    read_load_d    = 1'b0;
    write_strobe_d = 1'b0;
    addr_err_d     = 1'b0;

    if (cs_n) begin
      // Deselect aborts whatever byte is in flight, even one completing now.
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      shift_d   = 8'd0;
      ovf_d     = 1'b0;
    end else begin
      shift_d   = byte_in;
      bit_cnt_d = bit_cnt_q + 3'd1;
      case (state_q)
        S_IDLE: state_d = S_CMD;
        S_CMD: begin
          if (byte_done) begin
            if (cmd_addr == 8'd0 || cmd_addr > MAX_ADDR) begin
              addr_err_d = 1'b1;
              state_d    = S_DISCARD;
            end else if (byte_in[7]) begin
              ptr_d   = cmd_addr;
              state_d = S_WDATA;
            end else begin
              read_addr_d = cmd_addr;
              read_load_d = 1'b1;
              state_d     = S_RHOLD;
            end
          end
        end
        S_WDATA: begin
          if (byte_done) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (ptr_q == 8'(i + 1)) regs_d[i] = byte_in;
            end
            write_addr_d   = ptr_q;
            write_strobe_d = 1'b1;
            ptr_d          = ptr_inc;
            if (ptr_inc > MAX_ADDR) begin
              ovf_d   = 1'b1;
              state_d = S_DISCARD;
            end
          end
        end
        S_DISCARD: begin
          // A burst that ran off the end reports the error on the next full byte.
          if (byte_done && ovf_q) begin
            addr_err_d = 1'b1;
            ovf_d      = 1'b0;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'd0;
      ptr_q          <= 8'd0;
      ovf_q          <= 1'b0;
      regs_q         <= '0;
      read_addr_q    <= 8'd0;
      write_addr_q   <= 8'd0;
      read_load_q    <= 1'b0;
      write_strobe_q <= 1'b0;
      addr_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      ptr_q          <= ptr_d;
      ovf_q          <= ovf_d;
      regs_q         <= regs_d;
      read_addr_q    <= read_addr_d;
      write_addr_q   <= write_addr_d;
      read_load_q    <= read_load_d;
      write_strobe_q <= write_strobe_d;
      addr_err_q     <= addr_err_d;
    end
  end

  assign regs         = regs_q;
  assign read_addr    = read_addr_q;
  assign write_addr   = write_addr_q;
  assign read_load    = read_load_q;
  assign write_strobe = write_strobe_q;
  assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_pico_receiver.sv
// Directed bench for pico_receiver: inputs change on the falling edge, the DUT
// samples on the rising edge, and outputs are observed just after falling edges.
module tb_pico_receiver;

  localparam int NR = 59;

  logic              sclk;
  logic              rstn;
  logic              cs_n;
  logic              pico;
  logic [NR-1:0][7:0] regs;
  logic [7:0]        read_addr;
  logic              read_load;
  logic              write_strobe;
  logic [7:0]        write_addr;
  logic              addr_err;

  logic [NR-1:0][7:0] exp_regs;
  int checks;
  int errors;
  int ws_tot, rl_tot, ae_tot;
  int ws_base, rl_base, ae_base;

  pico_receiver #(.NUM_REGS(NR)) dut (
    .sclk        (sclk),
    .rstn        (rstn),
    .cs_n        (cs_n),
    .pico        (pico),
    .regs        (regs),
    .read_addr   (read_addr),
    .read_load   (read_load),
    .write_strobe(write_strobe),
    .write_addr  (write_addr),
    .addr_err    (addr_err)
  );

  // Clock
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Pulse counters: each strobe is one full period wide, so one falling edge sees it.
  initial begin
    ws_tot = 0;
    rl_tot = 0;
    ae_tot = 0;
  end
  always @(negedge sclk) begin
    if (write_strobe === 1'b1) ws_tot++;
    if (read_load === 1'b1) rl_tot++;
    if (addr_err === 1'b1) ae_tot++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    checks++;
    assert (regs === exp_regs) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, regs, exp_regs);
    end
  endtask

  task automatic mark();
    ws_base = ws_tot;
    rl_base = rl_tot;
    ae_base = ae_tot;
  endtask

  task automatic send_bit(input logic b);
    @(negedge sclk);
    cs_n = 1'b0;
    pico = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  // Deselect, let one rising edge see it, then settle just past a falling edge.
  task automatic cs_high();
    @(negedge sclk);
    cs_n = 1'b1;
    pico = 1'b0;
    @(negedge sclk);
    #1;
  endtask

  initial begin
    logic [7:0] d;
    checks   = 0;
    errors   = 0;
    exp_regs = '0;
    rstn = 1'b0;
    cs_n = 1'b1;
    pico = 1'b0;
    repeat (3) @(negedge sclk);
    #1;

    // Reset state
    check_regs("reset_regs");
    check("reset_read_addr", 32'(read_addr), 32'd0);
    check("reset_write_addr", 32'(write_addr), 32'd0);
    check("reset_read_load", 32'(read_load), 32'd0);
    check("reset_write_strobe", 32'(write_strobe), 32'd0);
    check("reset_addr_err", 32'(addr_err), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge sclk);

    // Single write of 0xA5 to address 5
    mark();
    send_byte(8'h85);
    send_byte(8'hA5);
    cs_high();
    exp_regs[4] = 8'hA5;
    check_regs("single_regs");
    check("single_write_addr", 32'(write_addr), 32'd5);
    check("single_strobes", 32'(ws_tot - ws_base), 32'd1);
    check("single_no_err", 32'(ae_tot - ae_base), 32'd0);

    // Burst from address 58 running past the end
    mark();
    send_byte(8'hBA);
    send_byte(8'h11);
    send_byte(8'h22);
    check("burst_err_before_third", 32'(ae_tot - ae_base), 32'd0);
    send_byte(8'h33);
    cs_high();
    exp_regs[57] = 8'h11;
    exp_regs[58] = 8'h22;
    check_regs("burst_regs");
    check("burst_strobes", 32'(ws_tot - ws_base), 32'd2);
    check("burst_err", 32'(ae_tot - ae_base), 32'd1);
    check("burst_write_addr", 32'(write_addr), 32'd59);

    // Read of address 7, then noise on pico while POCI shifts
    mark();
    send_byte(8'h07);
    @(negedge sclk);
    #1;
    check("read_load_high", 32'(read_load), 32'd1);
    check("read_addr", 32'(read_addr), 32'd7);
    pico = 1'b1;
    @(negedge sclk);
    #1;
    check("read_load_low", 32'(read_load), 32'd0);
    for (int i = 0; i < 12; i++) send_bit(1'(i % 2));
    cs_high();
    check("read_single_load", 32'(rl_tot - rl_base), 32'd1);
    check("read_addr_hold", 32'(read_addr), 32'd7);
    check("read_no_write", 32'(ws_tot - ws_base), 32'd0);
    check("read_no_err", 32'(ae_tot - ae_base), 32'd0);
    check_regs("read_regs");

    // Illegal addresses: write to 0, read of 60
    mark();
    send_byte(8'h80);
    send_byte(8'hFF);
    cs_high();
    check("illegal0_err", 32'(ae_tot - ae_base), 32'd1);
    send_byte(8'h3C);
    send_byte(8'h55);
    cs_high();
    check("illegal60_err", 32'(ae_tot - ae_base), 32'd2);
    check("illegal_no_load", 32'(rl_tot - rl_base), 32'd0);
    check("illegal_no_write", 32'(ws_tot - ws_base), 32'd0);
    check("illegal_read_addr", 32'(read_addr), 32'd7);
    check_regs("illegal_regs");

    // Abort after 5 and after 7 data bits of a write to address 3
    mark();
    send_byte(8'h83);
    d = 8'hFF;
    for (int i = 0; i < 5; i++) send_bit(d[i]);
    cs_high();
    check_regs("abort5_regs");
    send_byte(8'h83);
    for (int i = 0; i < 7; i++) send_bit(d[i]);
    cs_high();
    check_regs("abort7_regs");
    check("abort_no_write", 32'(ws_tot - ws_base), 32'd0);
    check("abort_no_err", 32'(ae_tot - ae_base), 32'd0);
    send_byte(8'h83);
    send_byte(8'h5A);
    cs_high();
    exp_regs[2] = 8'h5A;
    check_regs("after_abort_regs");
    check("after_abort_write_addr", 32'(write_addr), 32'd3);

    // Asynchronous reset during data bit 4
    send_byte(8'h84);
    d = 8'h3C;
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    @(negedge sclk);
    pico = d[4];
    #1;
    rstn = 1'b0;
    #1;
    exp_regs = '0;
    check_regs("midreset_regs");
    check("midreset_write_addr", 32'(write_addr), 32'd0);
    check("midreset_read_addr", 32'(read_addr), 32'd0);
    check("midreset_strobe", 32'(write_strobe), 32'd0);
    #1;
    rstn = 1'b1;
    cs_high();
    mark();
    send_byte(8'h81);
    send_byte(8'h99);
    cs_high();
    exp_regs[0] = 8'h99;
    check_regs("post_reset_regs");
    check("post_reset_write_addr", 32'(write_addr), 32'd1);
    check("post_reset_strobes", 32'(ws_tot - ws_base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
